// File: rtl/bus_pkg.sv
// Shared types and widths for the two-master bus arbiter and its watchdog.
package bus_pkg;

  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int TIMEOUT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } size_t;

endpackage

// File: rtl/bus_watchdog.sv
// Counts BUSY cycles; expired marks the cycle that is the timeout_cycles-th BUSY cycle.
module bus_watchdog
  import bus_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 enable,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  output logic                 expired
);

  logic [TIMEOUT_W-1:0] count;

  always_ff @(posedge clk_i) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // count holds the number of BUSY cycles already completed
  assign expired = enable && (count == (timeout_cycles - 1'b1));

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of a single bus controller, with BUSY timeout.
//   state   | meaning
//   IDLE    | no transfer; any request is granted on the next edge
//   BUSY    | granted master's request driven to the bus controller
//   RELEASE | one cycle with bus_access_o low so the controller drops its ack
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              m0_req_i,
  input  logic              m0_wr_en_i,
  input  logic              m0_rd_en_i,
  input  logic [1:0]        m0_size_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_wdata_i,
  output logic [DATA_W-1:0] m0_rdata_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic              m1_req_i,
  input  logic              m1_wr_en_i,
  input  logic              m1_rd_en_i,
  input  logic [1:0]        m1_size_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_wdata_i,
  output logic [DATA_W-1:0] m1_rdata_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              bus_access_o,
  output logic              wr_en_o,
  output logic              rd_en_o,
  output logic [1:0]        size_select_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] write_data_o,
  input  logic [DATA_W-1:0] read_data_i,
  input  logic              bus_ack_i
);

  localparam logic [TIMEOUT_W-1:0] TIMEOUT_VAL = TIMEOUT_W'(TIMEOUT_CYCLES);

  state_t state, state_next;
  logic   grant;
  logic   last_grant;
  logic   any_req;
  logic   sel;
  logic   expired;
  logic   start;
  logic   done;

  assign any_req = m0_req_i | m1_req_i;
  // Under contention the master that did not win last time goes first
  assign sel     = (m0_req_i && m1_req_i) ? ~last_grant : m1_req_i;
  assign start   = (state == ST_IDLE) && any_req;
  assign done    = (state == ST_BUSY) && (bus_ack_i || expired);

  bus_watchdog u_watchdog (
    .clk_i          (clk_i),
    .rst_n          (rst_n),
    .clear          (start),
    .enable         (state == ST_BUSY),
    .timeout_cycles (TIMEOUT_VAL),
    .expired        (expired)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      m0_ack_o   <= 1'b0;
      m0_err_o   <= 1'b0;
      m0_rdata_o <= '0;
      m1_ack_o   <= 1'b0;
      m1_err_o   <= 1'b0;
      m1_rdata_o <= '0;
    end else begin
      state      <= state_next;
      m0_ack_o   <= 1'b0;
      m0_err_o   <= 1'b0;
      m0_rdata_o <= '0;
      m1_ack_o   <= 1'b0;
      m1_err_o   <= 1'b0;
      m1_rdata_o <= '0;
      if (start) begin
        grant      <= sel;
        last_grant <= sel;
      end
      // A real ack wins over a coincident timeout
      if (done) begin
        if (grant) begin
          m1_ack_o   <= 1'b1;
          m1_err_o   <= ~bus_ack_i;
          m1_rdata_o <= (bus_ack_i && rd_en_o) ? read_data_i : '0;
        end else begin
          m0_ack_o   <= 1'b1;
          m0_err_o   <= ~bus_ack_i;
          m0_rdata_o <= (bus_ack_i && rd_en_o) ? read_data_i : '0;
        end
      end
    end
  end

  always_comb begin
    state_next    = state;
    bus_access_o  = 1'b0;
    wr_en_o       = 1'b0;
    rd_en_o       = 1'b0;
    size_select_o = '0;
    addr_o        = '0;
    write_data_o  = '0;
    case (state)
      ST_IDLE: begin
        if (any_req) state_next = ST_BUSY;
      end
      ST_BUSY: begin
        bus_access_o  = 1'b1;
        wr_en_o       = grant ? m1_wr_en_i : m0_wr_en_i;
        rd_en_o       = grant ? m1_rd_en_i : m0_rd_en_i;
        size_select_o = grant ? m1_size_i  : m0_size_i;
        addr_o        = grant ? m1_addr_i  : m0_addr_i;
        write_data_o  = grant ? m1_wdata_i : m0_wdata_i;
        if (bus_ack_i || expired) state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_bus_arbiter;

  logic        clk_i;
  logic        rst_n;
  logic        m0_req_i, m0_wr_en_i, m0_rd_en_i;
  logic [1:0]  m0_size_i;
  logic [15:0] m0_addr_i;
  logic [31:0] m0_wdata_i, m0_rdata_o;
  logic        m0_ack_o, m0_err_o;
  logic        m1_req_i, m1_wr_en_i, m1_rd_en_i;
  logic [1:0]  m1_size_i;
  logic [15:0] m1_addr_i;
  logic [31:0] m1_wdata_i, m1_rdata_o;
  logic        m1_ack_o, m1_err_o;
  logic        bus_access_o, wr_en_o, rd_en_o;
  logic [1:0]  size_select_o;
  logic [15:0] addr_o;
  logic [31:0] write_data_o;
  logic [31:0] read_data_i;
  logic        bus_ack_i;

  int checks = 0;
  int errors = 0;

  bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .rst_n(rst_n),
    .m0_req_i(m0_req_i), .m0_wr_en_i(m0_wr_en_i), .m0_rd_en_i(m0_rd_en_i),
    .m0_size_i(m0_size_i), .m0_addr_i(m0_addr_i), .m0_wdata_i(m0_wdata_i),
    .m0_rdata_o(m0_rdata_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req_i), .m1_wr_en_i(m1_wr_en_i), .m1_rd_en_i(m1_rd_en_i),
    .m1_size_i(m1_size_i), .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i),
    .m1_rdata_o(m1_rdata_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .bus_access_o(bus_access_o), .wr_en_o(wr_en_o), .rd_en_o(rd_en_o),
    .size_select_o(size_select_o), .addr_o(addr_o), .write_data_o(write_data_o),
    .read_data_i(read_data_i), .bus_ack_i(bus_ack_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, actual running, required finished");
    $fatal(1);
  end

  task automatic clear_inputs();
    m0_req_i = 0; m0_wr_en_i = 0; m0_rd_en_i = 0; m0_size_i = 0; m0_addr_i = 0; m0_wdata_i = 0;
    m1_req_i = 0; m1_wr_en_i = 0; m1_rd_en_i = 0; m1_size_i = 0; m1_addr_i = 0; m1_wdata_i = 0;
    bus_ack_i = 0; read_data_i = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    m0_req_i = 1; m0_rd_en_i = 1; m0_addr_i = 16'h00FF;
    @(negedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({bus_access_o, wr_en_o, rd_en_o, size_select_o, addr_o, write_data_o} !== 53'd0) begin
      errors++;
      $display("FAIL reset_downstream: actual %h required 0", {bus_access_o, wr_en_o, rd_en_o, size_select_o, addr_o, write_data_o});
    end
    checks++;
    if ({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, m0_rdata_o, m1_rdata_o} !== 68'd0) begin
      errors++;
      $display("FAIL reset_master_outs: actual %h required 0", {m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, m0_rdata_o, m1_rdata_o});
    end
    clear_inputs();
    rst_n = 1;
    @(negedge clk_i);
  endtask

  task automatic test_single_read();
    m0_req_i = 1; m0_rd_en_i = 1; m0_addr_i = 16'h0040; m0_size_i = 2'd2;
    read_data_i = 32'h0BAD0BAD;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk_i);
      checks++;
      if ({bus_access_o, rd_en_o, wr_en_o, addr_o} !== {3'b110, 16'h0040}) begin
        errors++;
        $display("FAIL read_busy_%0d: actual %b/%b/%b/%h required 1/1/0/0040", i, bus_access_o, rd_en_o, wr_en_o, addr_o);
      end
      if (i == 4) begin
        bus_ack_i = 1; read_data_i = 32'hDEADBEEF;
      end
    end
    @(negedge clk_i);
    checks++;
    if ({m0_ack_o, m0_err_o, m0_rdata_o, bus_access_o, m1_ack_o} !== {2'b10, 32'hDEADBEEF, 2'b00}) begin
      errors++;
      $display("FAIL read_ack: actual ack=%b err=%b rdata=%h access=%b m1_ack=%b required 1 0 deadbeef 0 0",
               m0_ack_o, m0_err_o, m0_rdata_o, bus_access_o, m1_ack_o);
    end
    bus_ack_i = 0; m0_req_i = 0; m0_rd_en_i = 0;
    @(negedge clk_i);
    checks++;
    if ({m0_ack_o, bus_access_o, m0_rdata_o} !== 34'd0) begin
      errors++;
      $display("FAIL read_idle: actual ack=%b access=%b rdata=%h required 0 0 0", m0_ack_o, bus_access_o, m0_rdata_o);
    end
  endtask

  task automatic test_single_write();
    m1_req_i = 1; m1_wr_en_i = 1; m1_addr_i = 16'h1004; m1_wdata_i = 32'h12345678; m1_size_i = 2'd2;
    read_data_i = 32'h55555555;
    @(negedge clk_i);
    checks++;
    if ({bus_access_o, wr_en_o, rd_en_o, size_select_o, addr_o, write_data_o} !== {3'b110, 2'd2, 16'h1004, 32'h12345678}) begin
      errors++;
      $display("FAIL write_busy: actual %b%b%b size=%0d addr=%h data=%h required 110 size=2 addr=1004 data=12345678",
               bus_access_o, wr_en_o, rd_en_o, size_select_o, addr_o, write_data_o);
    end
    bus_ack_i = 1;
    @(negedge clk_i);
    checks++;
    if ({m1_ack_o, m1_err_o, m1_rdata_o, m0_ack_o} !== {2'b10, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL write_ack: actual ack=%b err=%b rdata=%h m0_ack=%b required 1 0 0 0", m1_ack_o, m1_err_o, m1_rdata_o, m0_ack_o);
    end
    clear_inputs();
    @(negedge clk_i);
  endtask

  task automatic test_contention();
    logic [15:0] exp_addr;
    do_reset();
    m0_req_i = 1; m0_wr_en_i = 1; m0_addr_i = 16'h0100; m0_wdata_i = 32'hAAAA0000;
    m1_req_i = 1; m1_rd_en_i = 1; m1_addr_i = 16'h0200;
    @(negedge clk_i);
    checks++;
    if ({addr_o, wr_en_o} !== {16'h0100, 1'b1}) begin
      errors++;
      $display("FAIL contention_first: actual addr=%h wr=%b required addr=0100 wr=1", addr_o, wr_en_o);
    end
    bus_ack_i = 1;
    @(negedge clk_i);
    checks++;
    if ({m0_ack_o, m1_ack_o} !== 2'b10) begin
      errors++;
      $display("FAIL contention_first_ack: actual m0=%b m1=%b required m0=1 m1=0", m0_ack_o, m1_ack_o);
    end
    bus_ack_i = 0; m0_req_i = 0;
    @(negedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({bus_access_o, addr_o, rd_en_o} !== {1'b1, 16'h0200, 1'b1}) begin
      errors++;
      $display("FAIL contention_second: actual access=%b addr=%h rd=%b required 1 0200 1", bus_access_o, addr_o, rd_en_o);
    end
    bus_ack_i = 1; read_data_i = 32'hA5A5C3C3;
    @(negedge clk_i);
    checks++;
    if ({m1_ack_o, m1_rdata_o, m0_ack_o} !== {1'b1, 32'hA5A5C3C3, 1'b0}) begin
      errors++;
      $display("FAIL contention_second_ack: actual m1=%b rdata=%h m0=%b required 1 a5a5c3c3 0", m1_ack_o, m1_rdata_o, m0_ack_o);
    end
    bus_ack_i = 0; m1_req_i = 0;
    @(negedge clk_i);
    m0_req_i = 1; m1_req_i = 1;
    for (int i = 0; i < 4; i++) begin
      exp_addr = (i % 2 == 0) ? 16'h0100 : 16'h0200;
      @(negedge clk_i);
      checks++;
      if (addr_o !== exp_addr) begin
        errors++;
        $display("FAIL alternate_grant_%0d: actual addr=%h required %h", i, addr_o, exp_addr);
      end
      bus_ack_i = 1;
      @(negedge clk_i);
      checks++;
      if ({m0_ack_o, m1_ack_o} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL alternate_ack_%0d: actual m0=%b m1=%b", i, m0_ack_o, m1_ack_o);
      end
      bus_ack_i = 0;
      @(negedge clk_i);
    end
    clear_inputs();
    @(negedge clk_i);
  endtask

  task automatic test_timeout();
    m0_req_i = 1; m0_rd_en_i = 1; m0_addr_i = 16'h0300;
    read_data_i = 32'hFFFFFFFF;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_i);
      checks++;
      if ({bus_access_o, m0_ack_o} !== 2'b10) begin
        errors++;
        $display("FAIL timeout_busy_%0d: actual access=%b ack=%b required 1 0", i, bus_access_o, m0_ack_o);
      end
    end
    @(negedge clk_i);
    checks++;
    if ({m0_ack_o, m0_err_o, m0_rdata_o, bus_access_o, m1_ack_o, m1_err_o} !== {2'b11, 32'd0, 3'b000}) begin
      errors++;
      $display("FAIL timeout_pulse: actual ack=%b err=%b rdata=%h access=%b m1=%b%b required 1 1 0 0 00",
               m0_ack_o, m0_err_o, m0_rdata_o, bus_access_o, m1_ack_o, m1_err_o);
    end
    clear_inputs();
    @(negedge clk_i);
    checks++;
    if ({m0_ack_o, m0_err_o, bus_access_o} !== 3'b000) begin
      errors++;
      $display("FAIL timeout_idle: actual ack=%b err=%b access=%b required 0 0 0", m0_ack_o, m0_err_o, bus_access_o);
    end
    m1_req_i = 1; m1_rd_en_i = 1; m1_addr_i = 16'h0404;
    @(negedge clk_i);
    checks++;
    if ({bus_access_o, addr_o} !== {1'b1, 16'h0404}) begin
      errors++;
      $display("FAIL timeout_recover: actual access=%b addr=%h required 1 0404", bus_access_o, addr_o);
    end
    bus_ack_i = 1;
    @(negedge clk_i);
    clear_inputs();
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid_busy();
    m1_req_i = 1; m1_wr_en_i = 1; m1_addr_i = 16'h0500; m1_wdata_i = 32'h0BB0BB00;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      checks++;
      if ({bus_access_o, wr_en_o, addr_o, write_data_o, m1_ack_o, m1_err_o, m0_ack_o} !== 53'd0) begin
        errors++;
        $display("FAIL reset_mid_busy_%0d: actual access=%b addr=%h m1_ack=%b m1_err=%b required all 0",
                 i, bus_access_o, addr_o, m1_ack_o, m1_err_o);
      end
    end
    rst_n = 1; m1_req_i = 0; m1_wr_en_i = 0;
    @(negedge clk_i);
    checks++;
    if ({m1_ack_o, m1_err_o, bus_access_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_no_ack: actual ack=%b err=%b access=%b required 0 0 0", m1_ack_o, m1_err_o, bus_access_o);
    end
    m0_req_i = 1; m0_rd_en_i = 1; m0_addr_i = 16'h0600;
    m1_req_i = 1; m1_rd_en_i = 1; m1_addr_i = 16'h0700;
    @(negedge clk_i);
    checks++;
    if (addr_o !== 16'h0600) begin
      errors++;
      $display("FAIL reset_contention: actual addr=%h required 0600", addr_o);
    end
    bus_ack_i = 1; read_data_i = 32'h00000600;
    @(negedge clk_i);
    checks++;
    if ({m0_ack_o, m1_ack_o, m0_rdata_o} !== {2'b10, 32'h00000600}) begin
      errors++;
      $display("FAIL reset_contention_ack: actual m0=%b m1=%b rdata=%h required 1 0 00000600", m0_ack_o, m1_ack_o, m0_rdata_o);
    end
    clear_inputs();
    @(negedge clk_i);
  endtask

  task automatic test_ack_timeout_coincide();
    m1_req_i = 1; m1_rd_en_i = 1; m1_addr_i = 16'h0800;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk_i);
      if (i == 8) begin
        bus_ack_i = 1; read_data_i = 32'hCAFEF00D;
      end
    end
    @(negedge clk_i);
    checks++;
    if ({m1_ack_o, m1_err_o, m1_rdata_o, m0_ack_o} !== {2'b10, 32'hCAFEF00D, 1'b0}) begin
      errors++;
      $display("FAIL coincide_ack: actual ack=%b err=%b rdata=%h m0_ack=%b required 1 0 cafef00d 0",
               m1_ack_o, m1_err_o, m1_rdata_o, m0_ack_o);
    end
    clear_inputs();
    @(negedge clk_i);
    checks++;
    if ({m1_ack_o, m1_err_o, bus_access_o} !== 3'b000) begin
      errors++;
      $display("FAIL coincide_idle: actual ack=%b err=%b access=%b required 0 0 0", m1_ack_o, m1_err_o, bus_access_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_contention();
    test_timeout();
    test_reset_mid_busy();
    test_ack_timeout_coincide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
